usb_bus_scheduler: RTL

USB_BUS_SCHEDULER -- requirements
Module: usb_bus_scheduler

---
 rtl/usb_bus_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/usb_bus_scheduler.sv
// usb_bus_scheduler
//   Arbitrates a half-duplex FTDI synchronous FIFO bus between a TX source
//   FIFO (FPGA -> host) and an RX sink FIFO (host -> FPGA). Bursts are
//   limited to BURST_MAX words per grant and each burst is followed by
//   TURNAROUND idle bus cycles. When both directions are ready at once the
//   grant alternates, starting with TX after reset.
//
// Parameters
//   BURST_MAX   max words per direction grant (1..65535)
//   TURNAROUND  idle bus cycles after each burst (1..15)
//
// Ports
//   clk_in      FTDI bus clock, all logic on its rising edge
//   rst_in      synchronous active-low reset
//   usb_txe     FTDI can accept a write word
//   usb_rxf     FTDI holds a read word
//   tx_avail    TX source FIFO non-empty
//   rx_space    RX sink FIFO not full
//   usb_wr      write strobe to FTDI
//   usb_rd      read strobe to FTDI
//   usb_oe      FTDI output-enable
//   data_drive  FPGA drives DATA/BE
//   tx_pop      one TX word consumed this cycle
//   rx_push     one RX word captured this cycle
//   busy        scheduler is not idle
//
// Optional feature (macro USB_SCHED_STATS_EN)
//   wr_words    free-running count of tx_pop, wraps at 2^32
//   rd_words    free-running count of rx_push, wraps at 2^32
//
// State table
//   state    | meaning
//   IDLE     | bus parked, evaluating tx/rx requests
//   WR_BURST | FPGA drives bus, writing words to FTDI
//   RD_OE    | one-cycle FTDI output-enable lead-in before reading
//   RD_BURST | FTDI drives bus, reading words into RX FIFO
//   GAP      | bus turnaround, everything released

module usb_bus_scheduler #(
  parameter int BURST_MAX  = 256,
  parameter int TURNAROUND = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        usb_txe,
  input  logic        usb_rxf,
  input  logic        tx_avail,
  input  logic        rx_space,
  output logic        usb_wr,
  output logic        usb_rd,
  output logic        usb_oe,
  output logic        data_drive,
  output logic        tx_pop,
  output logic        rx_push,
  output logic        busy
`ifdef USB_SCHED_STATS_EN
  ,
  output logic [31:0] wr_words,
  output logic [31:0] rd_words
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_OE    = 3'd2,
    RD_BURST = 3'd3,
    GAP      = 3'd4
  } state_t;

  localparam logic        DIR_TX    = 1'b0;
  localparam logic        DIR_RX    = 1'b1;
  localparam logic [16:0] BURST_LIM = 17'(BURST_MAX);
  localparam logic [3:0]  GAP_LOAD  = 4'(TURNAROUND - 1);

  state_t      state, state_nxt;
  logic [15:0] word_cnt, word_cnt_nxt;
  logic [3:0]  gap_cnt, gap_cnt_nxt;
  logic        last_dir, last_dir_nxt;

  logic        tx_req, rx_req;
  logic [16:0] word_inc;
  logic        last_word;

  assign tx_req    = usb_txe & tx_avail;
  assign rx_req    = usb_rxf & rx_space;
  // 17-bit so BURST_MAX = 65535 compares without overflow
  assign word_inc  = {1'b0, word_cnt} + 17'd1;
  assign last_word = (word_inc == BURST_LIM);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      word_cnt <= 16'd0;
      gap_cnt  <= 4'd0;
      last_dir <= DIR_RX;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      last_dir <= last_dir_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    gap_cnt_nxt  = gap_cnt;
    last_dir_nxt = last_dir;
    usb_wr       = 1'b0;
    usb_rd       = 1'b0;
    usb_oe       = 1'b0;
    data_drive   = 1'b0;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        // On contention, TX wins only if RX had the previous grant
        if (tx_req && (!rx_req || last_dir == DIR_RX)) begin
          state_nxt    = WR_BURST;
          word_cnt_nxt = 16'd0;
          last_dir_nxt = DIR_TX;
        end else if (rx_req) begin
          state_nxt    = RD_OE;
          word_cnt_nxt = 16'd0;
          last_dir_nxt = DIR_RX;
        end
      end

      WR_BURST: begin
        data_drive = 1'b1;
        usb_wr     = tx_avail;
        tx_pop     = tx_avail & usb_txe;
        if (tx_pop) begin
          word_cnt_nxt = word_inc[15:0];
        end
        if (!usb_txe || !tx_avail || (tx_pop && last_word)) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end

      RD_OE: begin
        usb_oe    = 1'b1;
        state_nxt = RD_BURST;
      end

      RD_BURST: begin
        usb_oe  = 1'b1;
        usb_rd  = rx_space;
        rx_push = rx_space & usb_rxf;
        if (rx_push) begin
          word_cnt_nxt = word_inc[15:0];
        end
        if (!usb_rxf || !rx_space || (rx_push && last_word)) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end

      GAP: begin
        // Down-counter loaded with TURNAROUND-1, leaves on terminal count
        if (gap_cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 4'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef USB_SCHED_STATS_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_words <= 32'd0;
      rd_words <= 32'd0;
    end else begin
      if (tx_pop) begin
        wr_words <= wr_words + 32'd1;
      end
      if (rx_push) begin
        rd_words <= rd_words + 32'd1;
      end
    end
  end
`endif

endmodule
